// File: rtl/fp_dac_scheduler.sv
// Round-robin scheduler sharing one calibrate/scale/clamp datapath among N_CH
// actuator channels, turning signed fixed-point setpoints into offset-binary DAC codes.
module fp_dac_scheduler #(
  parameter int FP_WIDTH  = 64,
  parameter int INT_WIDTH = 16,
  parameter int DAC_WIDTH = 14,
  parameter int N_CH      = 4,
  parameter int CH_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [FP_WIDTH-1:0]      cfg_data,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*FP_WIDTH-1:0] req_data,
  output logic [N_CH-1:0]          req_ready,
  output logic                     dac_valid,
  output logic [CH_W-1:0]          dac_ch,
  output logic [DAC_WIDTH-1:0]     dac_code,
  output logic                     dac_sat,
  output logic                     busy
);

  localparam int FRAC = FP_WIDTH - INT_WIDTH;
  localparam int PW   = 2 * FP_WIDTH;
  localparam int RW   = 2 * INT_WIDTH + 1;

  localparam logic signed [FP_WIDTH-1:0] GAIN_ONE =
    {{(INT_WIDTH-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  // About -819.2 in the setpoint format: +/-10 V maps onto +/-8192 codes.
  localparam logic signed [FP_WIDTH-1:0] K_SCALE =
    {16'hFCCC, {((FP_WIDTH-16)/4){4'hC}}};
  localparam logic signed [PW-1:0] HALF_LSB =
    {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [RW:0] CODE_MID =
    {{(RW+1-DAC_WIDTH){1'b0}}, 1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam logic signed [RW:0] CODE_MAX =
    {{(RW+1-DAC_WIDTH){1'b0}}, {DAC_WIDTH{1'b1}}};

  function automatic logic signed [FP_WIDTH-1:0] fx_mul(
    input logic signed [FP_WIDTH-1:0] a,
    input logic signed [FP_WIDTH-1:0] b
  );
    logic signed [PW-1:0] prod;
    prod = PW'(a) * PW'(b);
    return prod[PW-1-INT_WIDTH:FRAC];
  endfunction

  // Integer part of d*K rounded half-up; kept wide so large setpoints clamp instead of wrapping.
  function automatic logic signed [RW-1:0] round_int(input logic signed [FP_WIDTH-1:0] d);
    logic signed [PW-1:0] q;
    q = PW'(d) * PW'(K_SCALE);
    q = (q >>> FRAC) + HALF_LSB;
    q = q >>> FRAC;
    return q[RW-1:0];
  endfunction

  function automatic logic [DAC_WIDTH:0] clamp_code(input logic signed [RW-1:0] r);
    logic signed [RW:0] c;
    c = {r[RW-1], r} + CODE_MID;
    if (c[RW])             return {1'b1, {DAC_WIDTH{1'b0}}};
    else if (c > CODE_MAX) return {1'b1, {DAC_WIDTH{1'b1}}};
    else                   return {1'b0, c[DAC_WIDTH-1:0]};
  endfunction

  logic [N_CH-1:0]            pending;
  logic [N_CH-1:0]            accept;
  logic [N_CH-1:0]            grant_vec;
  logic                       grant_any;
  logic [CH_W-1:0]            grant_ch;
  logic [CH_W-1:0]            rr;
  logic signed [FP_WIDTH-1:0] setpoint [N_CH];
  logic signed [FP_WIDTH-1:0] gain     [N_CH];
  logic signed [FP_WIDTH-1:0] offset   [N_CH];

  logic                       vld_p1, vld_p2;
  logic [CH_W-1:0]            ch_p1, ch_p2;
  logic signed [FP_WIDTH-1:0] p_p1, off_p1, d_p2;
  logic signed [FP_WIDTH-1:0] p_s1;
  logic [DAC_WIDTH:0]         res_s3;

  assign accept    = req_valid & ~pending;
  assign req_ready = ~pending;
  assign busy      = (|pending) | vld_p1 | vld_p2 | dac_valid;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(rr) + k) % N_CH;
      if (en && !grant_any && pending[idx]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec[grant_ch] = 1'b1;
  end

  assign p_s1   = fx_mul(setpoint[grant_ch], gain[grant_ch]);
  assign res_s3 = clamp_code(round_int(d_p2));

  // Setpoint holding registers and datapath stages carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (accept[i]) setpoint[i] <= req_data[i*FP_WIDTH +: FP_WIDTH];
    end
    // Stage 1: calibrated product, operands sampled at issue
    if (grant_any) begin
      p_p1   <= p_s1;
      off_p1 <= offset[grant_ch];
    end
    // Stage 2: offset removal
    if (vld_p1) d_p2 <= p_p1 - off_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      rr        <= CH_W'(N_CH-1);
      vld_p1    <= 1'b0;
      ch_p1     <= '0;
      vld_p2    <= 1'b0;
      ch_p2     <= '0;
      dac_valid <= 1'b0;
      dac_ch    <= '0;
      dac_code  <= '0;
      dac_sat   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        gain[i]   <= GAIN_ONE;
        offset[i] <= '0;
      end
    end else begin
      pending <= (pending & ~grant_vec) | accept;
      if (grant_any) rr <= grant_ch;

      vld_p1 <= grant_any;
      if (grant_any) ch_p1 <= grant_ch;

      vld_p2 <= vld_p1;
      if (vld_p1) ch_p2 <= ch_p1;

      // Stage 3: scale, round and clamp into the output registers
      dac_valid <= vld_p2;
      if (vld_p2) begin
        dac_ch   <= ch_p2;
        dac_sat  <= res_s3[DAC_WIDTH];
        dac_code <= res_s3[DAC_WIDTH-1:0];
      end

      if (cfg_we && (int'(cfg_ch) < N_CH)) begin
        if (cfg_sel) offset[cfg_ch] <= cfg_data;
        else         gain[cfg_ch]   <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_fp_dac_scheduler.sv
// Directed bench for fp_dac_scheduler: conversion values, arbitration order,
// enable gating, calibration timing and asynchronous reset.
module tb_fp_dac_scheduler;

  localparam int FPW = 64;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int DW  = 14;

  localparam logic [FPW-1:0] FX_ZERO  = 64'h0000_0000_0000_0000;
  localparam logic [FPW-1:0] FX_ONE   = 64'h0001_0000_0000_0000;
  localparam logic [FPW-1:0] FX_TWO   = 64'h0002_0000_0000_0000;
  localparam logic [FPW-1:0] FX_TEN   = 64'h000A_0000_0000_0000;
  localparam logic [FPW-1:0] FX_MTEN  = 64'hFFF6_0000_0000_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               cfg_we;
  logic               cfg_sel;
  logic [CHW-1:0]     cfg_ch;
  logic [FPW-1:0]     cfg_data;
  logic [NCH-1:0]     req_valid;
  logic [NCH*FPW-1:0] req_data;
  logic [NCH-1:0]     req_ready;
  logic               dac_valid;
  logic [CHW-1:0]     dac_ch;
  logic [DW-1:0]      dac_code;
  logic               dac_sat;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_dac_scheduler #(
    .FP_WIDTH(FPW), .INT_WIDTH(16), .DAC_WIDTH(DW), .N_CH(NCH), .CH_W(CHW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dac_valid(dac_valid), .dac_ch(dac_ch), .dac_code(dac_code), .dac_sat(dac_sat),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int ch, input logic [FPW-1:0] v);
    req_valid[ch] = 1'b1;
    req_data[ch*FPW +: FPW] = v;
  endtask

  task automatic wait_dac(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dac_valid && n < 20);
  endtask

  task automatic cfg_write(input logic sel, input int ch, input logic [FPW-1:0] v);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = CHW'(ch); cfg_data = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic single(input string tag, input int ch, input logic [FPW-1:0] v,
                        input logic [DW-1:0] code, input logic sat);
    int n;
    post(ch, v);
    tick();
    req_valid = '0;
    wait_dac(n);
    check({tag, "_lat"}, n, 3);
    check({tag, "_vld"}, dac_valid, 1);
    check({tag, "_ch"}, dac_ch, ch);
    check({tag, "_code"}, dac_code, code);
    check({tag, "_sat"}, dac_sat, sat);
    tick();
    check({tag, "_pulse"}, dac_valid, 0);
    check({tag, "_hold"}, dac_code, code);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int seen;
    logic [DW-1:0] exp_code [NCH];
    logic          exp_sat  [NCH];
    exp_code = '{14'd8192, 14'd7373, 14'd0, 14'd16383};
    exp_sat  = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0;
    cfg_data = '0; req_valid = '0; req_data = '0;
    tick();
    tick();
    check("rst_ready", req_ready, 4'hF);
    check("rst_valid", dac_valid, 0);
    check("rst_ch", dac_ch, 0);
    check("rst_code", dac_code, 0);
    check("rst_sat", dac_sat, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    single("zero", 0, FX_ZERO, 14'd8192, 1'b0);
    single("one", 1, FX_ONE, 14'd7373, 1'b0);
    single("ten", 1, FX_TEN, 14'd0, 1'b0);
    single("mten", 1, FX_MTEN, 14'd16383, 1'b1);

    cfg_write(1'b0, 2, FX_TWO);
    cfg_write(1'b1, 2, FX_ONE);
    single("cal2", 2, FX_ONE, 14'd7373, 1'b0);

    // gain write lands in the issue cycle of ch3: old gain must be used
    post(3, FX_ONE);
    tick();
    req_valid = '0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd3; cfg_data = FX_TWO;
    tick();
    cfg_we = 1'b0;
    wait_dac(n);
    check("calold_lat", n, 2);
    check("calold_code", dac_code, 7373);
    tick();
    single("calnew", 3, FX_ONE, 14'd6554, 1'b0);

    do_reset();
    post(0, FX_ZERO); post(1, FX_ONE); post(2, FX_TEN); post(3, FX_MTEN);
    tick();
    req_valid = '0;
    wait_dac(n);
    check("all4_lat", n, 3);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("all4_vld%0d", k), dac_valid, 1);
      check($sformatf("all4_ch%0d", k), dac_ch, k);
      check($sformatf("all4_code%0d", k), dac_code, exp_code[k]);
      check($sformatf("all4_sat%0d", k), dac_sat, exp_sat[k]);
      tick();
    end
    check("all4_end", dac_valid, 0);

    post(0, FX_ZERO); post(2, FX_ZERO);
    wait_dac(n);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("alt_vld%0d", k), dac_valid, 1);
      check($sformatf("alt_ch%0d", k), dac_ch, (k % 2 == 0) ? 0 : 2);
      tick();
    end
    req_valid = '0;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("alt_drain", busy, 0);

    en = 1'b0;
    post(3, FX_ZERO);
    tick();
    req_valid = '0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (dac_valid) seen++;
      tick();
    end
    check("en0_novalid", seen, 0);
    check("en0_busy", busy, 1);
    check("en0_ready3", req_ready[3], 0);
    check("en0_ready_other", req_ready[2:0], 3'b111);
    en = 1'b1;
    wait_dac(n);
    check("en1_lat", n, 3);
    check("en1_ch", dac_ch, 3);
    check("en1_code", dac_code, 8192);
    tick();

    post(0, FX_ONE); post(1, FX_ONE); post(2, FX_ONE);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("midrst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 4'hF);
    check("midrst_valid", dac_valid, 0);
    check("midrst_ch", dac_ch, 0);
    check("midrst_code", dac_code, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dac_valid) seen++;
    end
    check("midrst_novalid", seen, 0);
    check("midrst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_dac_scheduler.md
Name: fp_dac_scheduler

Overview:
- Shares one pipelined fixed-point-to-DAC conversion datapath among N_CH SPGD actuator channels.
- Each channel posts a Q(INT_WIDTH).(FP_WIDTH-INT_WIDTH) signed setpoint through a valid/ready handshake.
- A round-robin arbiter issues at most one channel per cycle into a 3-stage calibrate/scale/clamp pipeline.
- Per-channel calibration gain and offset are held locally and written through a config port.

Parameters:
- FP_WIDTH, 64, fixed-point word width.
- INT_WIDTH, 16, integer bits of the fixed-point format (signed).
- DAC_WIDTH, 14, DAC code width.
- N_CH, 4, number of channels (2..16).
- CH_W, 2, channel index width; must equal clog2(N_CH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  when low, no new issues; in-flight entries drain.
- cfg_we  in  1  calibration write strobe.
- cfg_sel  in  1  0 = gain, 1 = offset.
- cfg_ch  in  CH_W  channel to write.
- cfg_data  in  FP_WIDTH  calibration value (fixed-point).
- req_valid  in  N_CH  per-channel setpoint valid.
- req_data  in  N_CH*FP_WIDTH  per-channel setpoints; channel i occupies bits [i*FP_WIDTH +: FP_WIDTH].
- req_ready  out  N_CH  per-channel holding register empty.
- dac_valid  out  1  one-cycle pulse, code valid.
- dac_ch  out  CH_W  channel of dac_code.
- dac_code  out  DAC_WIDTH  offset-binary DAC code.
- dac_sat  out  1  code was clamped.
- busy  out  1  any pending or in-flight entry.

Behaviour:
- Reset values: gain[i] = 1.0 (0x0001 followed by zeros), offset[i] = 0, pending = 0, all pipe valids = 0, rr pointer = N_CH-1.
- Reset outputs: req_ready = all ones, dac_valid = 0, dac_ch = 0, dac_code = 0, dac_sat = 0, busy = 0.
- Reset asserted mid-operation discards all pending and in-flight data immediately.
- Intake: req_ready[i] = !pending[i]. On req_valid[i] & req_ready[i], capture the setpoint and set pending[i] next cycle.
- Issue: when en = 1 and any pending bit is set, grant the first pending channel searching from rr+1 upward with wrap.
  - On grant: clear pending[i], set rr = i, and load stage 1 with the setpoint, gain[i], offset[i] and the channel index.
- A channel may be re-accepted in the cycle after its issue, giving one grant per cycle sustained.
- Simultaneous grant of channel i and new req_valid[i] in the same cycle: not accepted, because ready was low.
- Calibration is sampled at issue. A cfg write to the channel being issued in the same cycle takes effect only on later issues.
- Stage S1: p = setpoint*gain, signed 2*FP_WIDTH bits; keep p[2*FP_WIDTH-1-INT_WIDTH : FP_WIDTH-INT_WIDTH].
- Stage S2: d = S1 - offset, signed, FP_WIDTH+1 bits; truncate to FP_WIDTH.
- Stage S3: q = d * K, with K = {16'hFCCC, C repeated} ≈ -819.2 (so ±10 V spans ±8192 codes).
  - r = integer part of q, rounded half-up (add 2^(FP_WIDTH-INT_WIDTH-1) before the arithmetic shift).
  - code = r + 2^(DAC_WIDTH-1).
  - If code < 0, output 0; if code > 2^DAC_WIDTH-1, output 2^DAC_WIDTH-1; set dac_sat in either case.
- Output registers load from S3. dac_valid is high exactly 3 cycles after the grant cycle.
- No output backpressure; throughput is one code per cycle.
- dac_code, dac_ch and dac_sat hold their last value while dac_valid = 0.
- en low: pending bits persist and intake continues. Pipeline drains; busy stays high until both pending and pipe are empty.
- busy = |pending | any stage valid | dac_valid.

Test Plan:
- Reset, then ch0 setpoint 0.0, default cal -> dac_valid 3 cycles after grant, dac_ch = 0, dac_code = 8192, dac_sat = 0.
- ch1 setpoint 1.0 -> r = -819, code 7373. Setpoint 10.0 -> code 0, sat 0. Setpoint -10.0 -> code clamps to 16383, sat 1.
- cfg gain[2] = 2.0, offset[2] = 1.0, setpoint 1.0 -> d = 1.0 -> code 7373. Cfg write landing in the issue cycle -> old cal used.
- All 4 channels valid the same cycle after reset -> grants in order 0, 1, 2, 3. Outputs on 4 consecutive cycles with matching dac_ch.
  - Re-assert ch0 and ch2 continuously -> alternating 0, 2, 0, 2 with no gaps.
- en = 0 with ch3 pending -> no dac_valid, busy = 1, req_ready[3] = 0. Raise en -> code appears 3 cycles after the grant.
- Assert rst_n low while 3 entries are in flight -> outputs and req_ready return to reset values at once, and no dac_valid after release.
